johnson_seq_ctrl: RTL and testbench

- Command-driven sequencer that owns and steps a WIDTH-bit Johnson (twisted-ring) counter.
- Accepts one command at a time over a valid/ready interface:
  - set a step-rate prescaler;
  - run N steps forward;
  - run N steps in reverse;
  - clear the counter.
- Exposes the counter state, a phase index and completion strobes.
- Sits between the TT user I/O decode and the Johnson counter outputs.

---
 rtl/johnson_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: command-driven sequencer owning a WIDTH-bit Johnson counter.
// Accepts SET_DIV / RUN_FWD / RUN_REV / CLEAR over valid/ready. A run steps the
// counter once every `div` cycles for N steps. It can be cut short by abort.
module johnson_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_arg,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             step,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SET_DIV = 2'd0,
    OP_RUN_FWD = 2'd1,
    OP_RUN_REV = 2'd2,
    OP_CLEAR   = 2'd3
  } op_e;

  localparam logic [PW-1:0] PH_MAX = PW'(2 * WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [7:0]       div_q, div_d;
  logic [7:0]       presc_q, presc_d;
  logic [7:0]       rem_q, rem_d;
  logic             rev_q, rev_d;
  logic             step_q, step_d;

  // Registered state; reset puts div back to 1 and abandons any run silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      phase_q <= '0;
      div_q   <= 8'd1;
      presc_q <= '0;
      rem_q   <= '0;
      rev_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      rev_q   <= rev_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic: command decode in IDLE, prescaled stepping in RUN.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    phase_d = phase_q;
    div_d   = div_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    rev_d   = rev_q;
    step_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (op_e'(cmd_op))
            OP_SET_DIV: div_d = (cmd_arg == 8'd0) ? 8'd1 : cmd_arg;
            OP_CLEAR: begin
              q_d     = '0;
              phase_d = '0;
            end
            OP_RUN_FWD, OP_RUN_REV: begin
              rev_d   = (op_e'(cmd_op) == OP_RUN_REV);
              rem_d   = cmd_arg;
              presc_d = '0;
              state_d = S_RUN;
            end
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (rem_q == 8'd0) begin
          state_d = S_DONE;
        end else if (presc_q == div_q - 8'd1) begin
          presc_d = '0;
          rem_d   = rem_q - 8'd1;
          step_d  = 1'b1;
          if (rev_q) begin
            q_d     = {~q_q[0], q_q[WIDTH-1:1]};
            phase_d = (phase_q == '0) ? PH_MAX : phase_q - PW'(1);
          end else begin
            q_d     = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            phase_d = (phase_q == PH_MAX) ? '0 : phase_q + PW'(1);
          end
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode straight from registered state.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    step      = step_q;
    q         = q_q;
    phase     = phase_q;
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl (WIDTH=8, PW=5). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_johnson_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_arg = 8'd0;
  logic       abort = 1'b0;
  logic [7:0] q;
  logic [4:0] phase;
  logic       step, done, busy;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int done_cnt = 0;
  int s0, d0;

  johnson_seq_ctrl #(.WIDTH(8), .PW(5)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .q(q), .phase(phase),
    .step(step), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the rising edge, where step/done are stable.
  always @(posedge clk) begin
    if (step) step_cnt = step_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Present one command; returns at the falling edge after the accepting edge T.
  task automatic send(input logic [1:0] op, input logic [7:0] arg);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    cyc(2);
    check("rst_q", q, 8'h00);
    check("rst_phase", phase, 5'd0);
    check("rst_step", step, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;

    // RUN_FWD 3 at div=1
    send(2'd1, 8'd3);
    check("f3_busy", busy, 1'b1);
    check("f3_ready", cmd_ready, 1'b0);
    check("f3_q0", q, 8'h00);
    cyc(1); check("f3_q1", q, 8'h01); check("f3_step1", step, 1'b1);
    cyc(1); check("f3_q2", q, 8'h03);
    cyc(1); check("f3_q3", q, 8'h07); check("f3_ph3", phase, 5'd3);
    cyc(1); check("f3_done", done, 1'b1); check("f3_step_lo", step, 1'b0);
    check("f3_ready_lo", cmd_ready, 1'b0);
    cyc(1); check("f3_done_lo", done, 1'b0); check("f3_ready_hi", cmd_ready, 1'b1);
    check("f3_busy_lo", busy, 1'b0);

    // SET_DIV 4, CLEAR, RUN_FWD 2
    send(2'd0, 8'd4);
    check("sd_ready", cmd_ready, 1'b1);
    check("sd_nodone", done, 1'b0);
    check("sd_q_kept", q, 8'h07);
    send(2'd3, 8'd0);
    check("clr_q", q, 8'h00);
    check("clr_phase", phase, 5'd0);
    check("clr_step", step, 1'b0);
    s0 = step_cnt; d0 = done_cnt;
    send(2'd1, 8'd2);
    cyc(3); check("d4_q_T3", q, 8'h00);
    cyc(1); check("d4_q_T4", q, 8'h01); check("d4_step_T4", step, 1'b1);
    cyc(3); check("d4_q_T7", q, 8'h01); check("d4_step_T7", step, 1'b0);
    cyc(1); check("d4_q_T8", q, 8'h03);
    cyc(1); check("d4_done", done, 1'b1);
    cyc(1); check("d4_ready", cmd_ready, 1'b1);
    check("d4_nsteps", step_cnt - s0, 2);
    check("d4_ndone", done_cnt - d0, 1);

    // SET_DIV 0 behaves as div=1; RUN_REV 1 from zero
    send(2'd0, 8'd0);
    send(2'd3, 8'd0);
    send(2'd2, 8'd1);
    cyc(1); check("rev_q", q, 8'h80); check("rev_phase", phase, 5'd15);
    cyc(1); check("rev_done", done, 1'b1);
    cyc(1); check("rev_ready", cmd_ready, 1'b1);

    // Full wrap: 16 forward steps
    send(2'd3, 8'd0);
    send(2'd1, 8'd16);
    cyc(8); check("wrap_q8", q, 8'hFF); check("wrap_ph8", phase, 5'd8);
    cyc(8); check("wrap_q16", q, 8'h00); check("wrap_ph16", phase, 5'd0);
    cyc(1); check("wrap_done", done, 1'b1);
    cyc(1);

    // RUN_FWD 0: no steps, done after T+1
    s0 = step_cnt;
    send(2'd1, 8'd0);
    check("n0_busy", busy, 1'b1);
    cyc(1); check("n0_done", done, 1'b1); check("n0_q", q, 8'h00);
    cyc(1); check("n0_ready", cmd_ready, 1'b1);
    check("n0_nsteps", step_cnt - s0, 0);

    // Abort after 3 steps at div=2, with CLEAR held on cmd_valid throughout
    send(2'd0, 8'd2);
    send(2'd1, 8'd10);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_arg = 8'd0;
    cyc(3); check("ab_ready_lo", cmd_ready, 1'b0);
    cyc(3); check("ab_q3", q, 8'h07); check("ab_ph3", phase, 5'd3);
    abort = 1'b1;
    cyc(1); check("ab_done", done, 1'b1); check("ab_q_hold", q, 8'h07);
    abort = 1'b0; cmd_valid = 1'b0;
    cyc(1); check("ab_ready", cmd_ready, 1'b1); check("ab_q_end", q, 8'h07);

    // Reset mid-run at q=0x1F with div=3, then div must be back to 1
    send(2'd3, 8'd0);
    send(2'd0, 8'd3);
    send(2'd1, 8'd10);
    cyc(15); check("mr_q", q, 8'h1F);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mr_rst_q", q, 8'h00);
    check("mr_rst_busy", busy, 1'b0);
    check("mr_rst_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    check("mr_nodone", done_cnt - d0, 0);
    send(2'd1, 8'd2);
    cyc(1); check("mr_div1_q1", q, 8'h01);
    cyc(1); check("mr_div1_q2", q, 8'h03);
    cyc(1); check("mr_div1_done", done, 1'b1);
    cyc(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
